// File: rtl/fm_discriminator_if.sv
// I/Q sample handshake and held frequency-estimate output
// for the FM discriminator.
interface fm_discriminator_if #(
    parameter int IQ_W  = 16,
    parameter int OUT_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IQ_W-1:0]  in_i;
    logic signed [IQ_W-1:0]  in_q;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    busy;

    modport master (
        output in_valid, in_i, in_q,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_valid, in_i, in_q,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/fm_discriminator.sv
// Cross-product FM discriminator: (p x c) / |c|^2 with an
// iterative restoring divider and symmetric saturation.
module fm_discriminator #(
    parameter int IQ_W  = 16,
    parameter int OUT_W = 32,
    parameter int FRAC  = 30
) (
    input  logic clk,
    input  logic rst_n,
    fm_discriminator_if.slave bus
);
    localparam int PW = 2*IQ_W + 1;
    localparam int RW = PW + OUT_W - 1;
    localparam int CW = $clog2(OUT_W);
    localparam logic signed [OUT_W-1:0] SMAX =
        {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t state, state_nx;

    logic signed [IQ_W-1:0]  ci, cq, pi, pq;
    logic [CW-1:0]           cnt;
    logic [RW-1:0]           rem, dsr;
    logic [OUT_W-2:0]        quo;
    logic                    sign, ovf, zero;
    logic signed [OUT_W-1:0] odata;
    logic                    ovalid;
    logic                    xfer;

    logic signed [2*IQ_W-1:0] pa, pb, sa, sb;
    logic signed [PW-1:0]     cross_c;
    logic [PW-1:0]            den_c, mag_c;
    logic [RW-1:0]            num_c, dsh_c;
    logic signed [OUT_W-1:0]  qs;

    assign xfer          = (state == IDLE) && bus.in_valid;
    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = odata;
    assign bus.out_valid = ovalid;

    always_comb begin
        pa      = pi * cq;
        pb      = pq * ci;
        sa      = ci * ci;
        sb      = cq * cq;
        cross_c = {pa[2*IQ_W-1], pa} - {pb[2*IQ_W-1], pb};
        den_c   = {1'b0, sa} + {1'b0, sb};
        mag_c   = cross_c[PW-1] ? -cross_c : cross_c;
        num_c   = RW'(mag_c) << FRAC;
        dsh_c   = RW'(den_c) << (OUT_W-1);
        qs      = {1'b0, quo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_nx = MULT;
            MULT: state_nx = DIV;
            DIV:  if (cnt == '0) state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci     <= '0;
            cq     <= '0;
            pi     <= '0;
            pq     <= '0;
            cnt    <= '0;
            rem    <= '0;
            dsr    <= '0;
            quo    <= '0;
            sign   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            odata  <= '0;
            ovalid <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            if (xfer) begin
                pi <= ci;
                pq <= cq;
                ci <= bus.in_i;
                cq <= bus.in_q;
            end
            if (state == MULT) begin
                sign <= cross_c[PW-1];
                zero <= (den_c == '0);
                ovf  <= (den_c != '0) && (num_c >= dsh_c);
                rem  <= num_c;
                dsr  <= dsh_c;
                quo  <= '0;
                cnt  <= CW'(OUT_W-1);
            end
            // First step tests bit OUT_W-1 (overflow) and shifts out of quo
            if (state == DIV) begin
                if (rem >= dsr) begin
                    rem <= rem - dsr;
                    quo <= {quo[OUT_W-3:0], 1'b1};
                end else begin
                    quo <= {quo[OUT_W-3:0], 1'b0};
                end
                dsr <= dsr >> 1;
                cnt <= cnt - CW'(1);
            end
            if (state == DONE) begin
                ovalid <= 1'b1;
                if (zero)     odata <= '0;
                else if (ovf) odata <= sign ? -SMAX : SMAX;
                else          odata <= sign ? -qs : qs;
            end
        end
    end
endmodule

// File: tb/tb_fm_discriminator.sv
// Scoreboard bench for fm_discriminator: arithmetic reference
// model, decoupled output monitor, latency and hold checks.
module tb_fm_discriminator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fm_discriminator_if #(.IQ_W(16), .OUT_W(32)) bus ();

    fm_discriminator #(
        .IQ_W(16),
        .OUT_W(32),
        .FRAC(30)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] data;
        int                 acc;
    } exp_t;

    exp_t   sbq[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     edges  = 0;
    longint hp_i   = 0;
    longint hp_q   = 0;
    logic signed [31:0] last_out = '0;

    always @(posedge clk) edges++;

    task automatic check(string name, logic signed [63:0] act,
                         logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ratio of cross product to power, scaled by 2^30, clamped
    function automatic logic signed [31:0] model(longint ci, longint cq);
        longint cr, den, mag;
        cr   = hp_i * cq - hp_q * ci;
        den  = ci * ci + cq * cq;
        hp_i = ci;
        hp_q = cq;
        if (den == 0) return '0;
        mag = ((cr < 0 ? -cr : cr) <<< 30) / den;
        if (mag > 64'sd2147483647) mag = 64'sd2147483647;
        return (cr < 0) ? 32'(-mag) : 32'(mag);
    endfunction

    task automatic send(input int si, input int sq, output int acc);
        int t;
        logic signed [31:0] e;
        bus.in_valid = 1'b1;
        bus.in_i     = si[15:0];
        bus.in_q     = sq[15:0];
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            acc = -1;
            bus.in_valid = 1'b0;
            return;
        end
        acc = edges + 1;
        e = model(longint'(si), longint'(sq));
        sbq.push_back('{e, acc});
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_out = '0;
        end else if (bus.out_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("out_data", bus.out_data, e.data);
                check("latency", edges - e.acc, 34);
            end
            last_out = bus.out_data;
        end else begin
            check("hold", bus.out_data, last_out);
        end
    end

    initial begin
        int a, b;
        int acc4[4];
        int si, sq;
        bus.in_valid = 1'b0;
        bus.in_i     = '0;
        bus.in_q     = '0;

        repeat (3) @(negedge clk);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        send(16384, 0, a);
        send(0, 16384, b);
        check("busy_after_accept", bus.busy, 1);
        check("ready_while_busy", bus.in_ready, 0);
        drain();

        send(0, 16384, a);
        send(16384, 0, a);
        drain();

        send(32767, 0, a);
        send(0, 1, a);
        send(32767, 0, a);
        send(0, 1, a);
        send(0, -1, a);
        drain();

        send(16384, 0, a);
        send(0, 0, a);
        send(16384, 0, a);
        drain();

        send(10000, 10000, acc4[0]);
        for (int k = 1; k < 4; k++) begin
            send(10000, 10000, acc4[k]);
            check("accept_spacing", acc4[k] - acc4[k-1], 35);
        end
        drain();

        // Abort a division in flight; output and history must clear
        send(0, 16384, a);
        send(16384, 0, a);
        drain();
        send(0, 16384, a);
        repeat (11) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_data", bus.out_data, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        sbq.delete();
        hp_i = 0;
        hp_q = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus.in_ready, 1);
        send(0, 16384, a);
        drain();

        for (int n = 0; n < 40; n++) begin
            si = int'($urandom_range(0, 65535)) - 32768;
            sq = int'($urandom_range(0, 65535)) - 32768;
            case ($urandom_range(0, 7))
                0: si = -32768;
                1: sq = -32768;
                2: begin si = 0; sq = 0; end
                default: ;
            endcase
            send(si, sq, a);
            idle(int'($urandom_range(0, 3)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
